// File: rtl/shr_64b_pipe.sv
// shr_64b_pipe: pipelined 64-bit logical/arithmetic right shifter with sticky output and global-stall valid/ready
module shr_64b_pipe #(
  parameter logic [5:0] STAGE_REG = 6'b001001,
  parameter bit         REG_OUT   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        arith_i,
  input  logic        carry_i,
  input  logic [5:0]  shift_i,
  input  logic [63:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [63:0] out_data_o,
  output logic        out_sticky_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);
  localparam bit COMB = (STAGE_REG == 6'd0) && !REG_OUT;
  logic [63:0] dd [0:6];
  logic        st [0:6];
  logic [5:0]  sh [0:6];
  logic        fl [0:6];
  logic        vl [0:6];
  logic        advance;
  assign advance    = COMB ? out_ready_i : (!out_valid_o || out_ready_i);
  assign in_ready_o = advance;
  assign dd[0] = in_data_i;
  assign st[0] = 1'b0;
  assign sh[0] = shift_i;
  assign fl[0] = arith_i ? in_data_i[63] : carry_i;
  assign vl[0] = in_valid_i;
  for (genvar k = 0; k < 6; k++) begin : g_stage
    localparam int N = 32 >> k;
    logic [63:0] cd;
    logic        cs;
    logic        sel;
    assign sel = sh[k][5-k];
    assign cd  = sel ? {{N{fl[k]}}, dd[k][63:N]} : dd[k];
    assign cs  = st[k] | (sel & |dd[k][N-1:0]);
    if (STAGE_REG[k]) begin : g_reg
      logic [63:0] rd;
      logic [5:0]  rsh;
      logic        rs, rf, rv;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rd  <= '0;
          rs  <= 1'b0;
          rsh <= '0;
          rf  <= 1'b0;
          rv  <= 1'b0;
        end else if (advance) begin
          rd  <= cd;
          rs  <= cs;
          rsh <= sh[k];
          rf  <= fl[k];
          rv  <= vl[k];
        end
      end
      assign dd[k+1] = rd;
      assign st[k+1] = rs;
      assign sh[k+1] = rsh;
      assign fl[k+1] = rf;
      assign vl[k+1] = rv;
    end else begin : g_comb
      assign dd[k+1] = cd;
      assign st[k+1] = cs;
      assign sh[k+1] = sh[k];
      assign fl[k+1] = fl[k];
      assign vl[k+1] = vl[k];
    end
  end
  if (REG_OUT) begin : g_out
    logic [63:0] od;
    logic        os, ov;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        od <= '0;
        os <= 1'b0;
        ov <= 1'b0;
      end else if (advance) begin
        od <= dd[6];
        os <= st[6];
        ov <= vl[6];
      end
    end
    assign out_data_o   = od;
    assign out_sticky_o = os;
    assign out_valid_o  = ov;
  end else begin : g_direct
    assign out_data_o   = dd[6];
    assign out_sticky_o = st[6];
    assign out_valid_o  = vl[6];
  end
endmodule

// File: tb/tb_shr_64b_pipe.sv
// tb_shr_64b_pipe: drives three shifter configurations (N=3, N=0, N=7) against a queue-based arithmetic reference model
module tb_shr_64b_pipe;
  typedef struct packed { logic [63:0] d; logic s; } res_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst [3];
  logic        arith [3];
  logic        carry [3];
  logic [5:0]  shift [3];
  logic [63:0] in_data [3];
  logic        in_valid [3];
  logic        in_ready [3];
  logic [63:0] out_data [3];
  logic        out_sticky [3];
  logic        out_valid [3];
  logic        out_ready [3];
  int checks = 0;
  int failures = 0;
  int sel = 0;
  int lat_of [3] = '{3, 0, 7};
  res_t exp_q [$];
  res_t held_r;
  logic held = 1'b0;
  logic accepted = 1'b0;
  logic delivered = 1'b0;
  logic [63:0] last_d = '0;
  logic last_s = 1'b0;
  shr_64b_pipe u_def (
    .clk_i(clk), .rst_i(rst[0]), .arith_i(arith[0]), .carry_i(carry[0]), .shift_i(shift[0]),
    .in_data_i(in_data[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .out_data_o(out_data[0]), .out_sticky_o(out_sticky[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0])
  );
  shr_64b_pipe #(.STAGE_REG(6'b000000), .REG_OUT(1'b0)) u_comb (
    .clk_i(clk), .rst_i(rst[1]), .arith_i(arith[1]), .carry_i(carry[1]), .shift_i(shift[1]),
    .in_data_i(in_data[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .out_data_o(out_data[1]), .out_sticky_o(out_sticky[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1])
  );
  shr_64b_pipe #(.STAGE_REG(6'b111111), .REG_OUT(1'b1)) u_full (
    .clk_i(clk), .rst_i(rst[2]), .arith_i(arith[2]), .carry_i(carry[2]), .shift_i(shift[2]),
    .in_data_i(in_data[2]), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .out_data_o(out_data[2]), .out_sticky_o(out_sticky[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2])
  );
  function automatic res_t model(input logic [63:0] d, input logic [5:0] s, input logic a, input logic c);
    logic [127:0] ext;
    logic [63:0]  mask;
    res_t r;
    ext  = {{64{a ? d[63] : c}}, d} >> s;
    mask = (64'd1 << s) - 64'd1;
    r.d  = ext[63:0];
    r.s  = |(d & mask);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask
  task automatic tick();
    res_t r;
    #1;
    delivered = 1'b0;
    accepted  = 1'b0;
    if (held) begin
      chk("hold_valid", 64'(out_valid[sel]), 64'd1);
      chk("hold_data", out_data[sel], held_r.d);
      chk("hold_sticky", 64'(out_sticky[sel]), 64'(held_r.s));
    end
    held = 1'b0;
    if (in_valid[sel] && in_ready[sel]) begin
      accepted = 1'b1;
      exp_q.push_back(model(in_data[sel], shift[sel], arith[sel], carry[sel]));
    end
    if (out_valid[sel] && out_ready[sel]) begin
      delivered = 1'b1;
      last_d = out_data[sel];
      last_s = out_sticky[sel];
      chk("order_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("result_data", out_data[sel], r.d);
        chk("result_sticky", 64'(out_sticky[sel]), 64'(r.s));
      end
    end else if (out_valid[sel]) begin
      held = 1'b1;
      held_r.d = out_data[sel];
      held_r.s = out_sticky[sel];
    end
    @(negedge clk);
  endtask
  task automatic send_one(input string tag, input logic [63:0] d, input logic [5:0] s, input logic a,
                          input logic c, input logic [63:0] ed, input logic es);
    int k;
    in_data[sel] = d;
    shift[sel] = s;
    arith[sel] = a;
    carry[sel] = c;
    in_valid[sel] = 1'b1;
    out_ready[sel] = 1'b1;
    tick();
    chk({tag, "_accept"}, 64'(accepted), 64'd1);
    in_valid[sel] = 1'b0;
    in_data[sel] = {$urandom, $urandom};
    k = 0;
    while (!delivered && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat_of[sel]));
    chk({tag, "_data"}, last_d, ed);
    chk({tag, "_sticky"}, 64'(last_s), 64'(es));
  endtask
  task automatic drain();
    int g;
    g = 0;
    in_valid[sel] = 1'b0;
    out_ready[sel] = 1'b1;
    while (exp_q.size() > 0 && g < 30) begin
      tick();
      g++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    #1;
    chk("drain_idle", 64'(out_valid[sel]), 64'd0);
    @(negedge clk);
  endtask
  task automatic sweep();
    int i, g;
    i = 0;
    g = 0;
    while (i < 64 && g < 2000) begin
      in_data[sel] = ~64'd0;
      shift[sel] = 6'(i);
      arith[sel] = 1'b0;
      carry[sel] = 1'b0;
      in_valid[sel] = 1'b1;
      out_ready[sel] = 1'($urandom_range(1));
      tick();
      if (accepted) i++;
      g++;
    end
    in_valid[sel] = 1'b0;
    chk("sweep_sent", 64'(i), 64'd64);
    drain();
  endtask
  task automatic random_run(input int beats);
    int sent, g;
    logic pending;
    sent = 0;
    g = 0;
    pending = 1'b0;
    while (sent < beats && g < 4000) begin
      if (!pending || lat_of[sel] > 0) begin
        if (!pending) pending = ($urandom_range(3) != 0);
        in_data[sel] = {$urandom, $urandom};
        shift[sel] = 6'($urandom_range(63));
        arith[sel] = 1'($urandom_range(1));
        carry[sel] = 1'($urandom_range(1));
      end
      in_valid[sel] = pending;
      out_ready[sel] = 1'($urandom_range(1));
      tick();
      if (accepted) begin
        pending = 1'b0;
        sent++;
      end
      g++;
    end
    in_valid[sel] = 1'b0;
    chk("random_sent", 64'(sent), 64'(beats));
    drain();
  endtask
  task automatic rst_mid();
    out_ready[sel] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[sel] = {$urandom, $urandom} | 64'd2;
      shift[sel] = 6'(i + 1);
      in_valid[sel] = 1'b1;
      tick();
    end
    in_valid[sel] = 1'b0;
    in_data[sel] = '0;
    #2 rst[sel] = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid[sel]), 64'd0);
    chk("rst_mid_data", out_data[sel], 64'd0);
    chk("rst_mid_sticky", 64'(out_sticky[sel]), 64'd0);
    exp_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst[sel] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_quiet", 64'(delivered), 64'd0);
    end
    send_one("after_rst", 64'd1, 6'd0, 1'b0, 1'b0, 64'd1, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      arith[i] = 1'b0;
      carry[i] = 1'b0;
      shift[i] = '0;
      in_data[i] = '0;
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      chk("reset_valid", 64'(out_valid[i]), 64'd0);
      chk("reset_data", out_data[i], 64'd0);
      chk("reset_sticky", 64'(out_sticky[i]), 64'd0);
      rst[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      chk("reset_ready", 64'(in_ready[i]), 64'd1);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      held = 1'b0;
      exp_q.delete();
      send_one("logical", 64'h0123_4567_89AB_CDEF, 6'd4, 1'b0, 1'b0, 64'h0012_3456_789A_BCDE, 1'b1);
      send_one("carry_fill", 64'h0123_4567_89AB_CDEF, 6'd4, 1'b0, 1'b1, 64'hF012_3456_789A_BCDE, 1'b1);
      send_one("arith63", 64'h8000_0000_0000_0000, 6'd63, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send_one("sticky_clr", 64'hFEDC_BA98_7654_3210, 6'd4, 1'b0, 1'b0, 64'h0FED_CBA9_8765_4321, 1'b0);
      send_one("sticky_set", 64'hFEDC_BA98_7654_3210, 6'd8, 1'b0, 1'b0, 64'h00FE_DCBA_9876_5432, 1'b1);
      send_one("shift0", 64'h8123_4567_89AB_CDEF, 6'd0, 1'b1, 1'b1, 64'h8123_4567_89AB_CDEF, 1'b0);
      send_one("logic63", 64'h8000_0000_0000_0001, 6'd63, 1'b0, 1'b0, 64'd1, 1'b1);
      sweep();
      random_run(150);
      rst_mid();
      drain();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
